pipelined_ripple_subtractor_32bit: RTL and testbench

PIPELINED_RIPPLE_SUBTRACTOR_32BIT -- requirements
Module: pipelined_ripple_subtractor_32bit

---
 rtl/pipelined_ripple_subtractor_32bit_pkg.sv | 25 ++
 rtl/pipelined_ripple_subtractor_32bit_rp_full_subtractor.sv | 16 +
 rtl/pipelined_ripple_subtractor_32bit.sv | 140 ++++++++++++++
 tb/tb_pipelined_ripple_subtractor_32bit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_ripple_subtractor_32bit_pkg.sv
// Shared defaults and small helpers for the pipelined ripple-borrow subtractor.
package pipelined_ripple_subtractor_32bit_pkg;

  localparam int PRS_DEFAULT_WIDTH  = 32;
  localparam int PRS_DEFAULT_STAGES = 4;

  // Number of operand bits a stage passes on to the next one. Middle stages
  // forward the operand bits above their own slice; the last stage has no
  // upper bits left and keeps only the operand sign bit for overflow.
  function automatic int fwd_width(input int width, input int stages, input int k);
    int slice;
    slice = width / stages;
    if (k < stages - 1) begin
      return width - (k + 1) * slice;
    end
    return 1;
  endfunction

  // Signed overflow of a - b - bin. It occurs only when the operand signs
  // differ and the result sign differs from the minuend sign.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/pipelined_ripple_subtractor_32bit_rp_full_subtractor.sv
// One-bit full subtractor cell: computes a - b - bin and the borrow out.
module rp_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borrow
);

  // Borrow when b exceeds a, or when a equals b and a borrow arrives.
  always_comb begin
    diff   = a ^ b ^ bin;
    borrow = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/pipelined_ripple_subtractor_32bit.sv
// Pipelined ripple-borrow subtractor. Each stage resolves one WIDTH/STAGES
// slice and hands its borrow, the accumulated low result bits and the still
// unprocessed upper operand bits to the next stage. A single advance signal
// moves the whole pipeline, so a stalled output freezes every stage.
module pipelined_ripple_subtractor_32bit
  import pipelined_ripple_subtractor_32bit_pkg::*;
#(
  parameter int WIDTH  = PRS_DEFAULT_WIDTH,
  parameter int STAGES = PRS_DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             Bout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  // WIDTH must be a multiple of STAGES; every stage handles an equal slice.
  localparam int SLICE = WIDTH / STAGES;

  logic pipe_adv;

  genvar gi, gj;

  generate
    for (gi = 0; gi < STAGES; gi++) begin : gen_stage
      // IW: operand bits entering this stage (own slice plus everything above).
      // DW: result bits known once this stage has run.
      // FW: operand bits carried forward to the next stage.
      localparam int IW = WIDTH - gi * SLICE;
      localparam int DW = (gi + 1) * SLICE;
      localparam int FW = fwd_width(WIDTH, STAGES, gi);

      logic [IW-1:0]    a_i;
      logic [IW-1:0]    b_i;
      logic             bin_i;
      logic             v_i;
      logic [SLICE:0]   brw;
      logic [SLICE-1:0] slice_d;
      logic [DW-1:0]    diff_new;
      logic [FW-1:0]    a_fwd;
      logic [FW-1:0]    b_fwd;

      logic             valid_q, valid_d;
      logic             borrow_q, borrow_d;
      logic [DW-1:0]    diff_q, diff_d;
      logic [FW-1:0]    a_q, a_d;
      logic [FW-1:0]    b_q, b_d;

      if (gi == 0) begin : gen_src_port
        assign a_i      = A;
        assign b_i      = B;
        assign bin_i    = bin;
        assign v_i      = in_valid;
        assign diff_new = slice_d;
      end else begin : gen_src_stage
        assign a_i      = gen_stage[gi-1].a_q;
        assign b_i      = gen_stage[gi-1].b_q;
        assign bin_i    = gen_stage[gi-1].borrow_q;
        assign v_i      = gen_stage[gi-1].valid_q;
        assign diff_new = {slice_d, gen_stage[gi-1].diff_q};
      end

      // Ripple-borrow chain across this stage's slice.
      assign brw[0] = bin_i;
      for (gj = 0; gj < SLICE; gj++) begin : gen_bit
        rp_full_subtractor u_fs (
          .a      (a_i[gj]),
          .b      (b_i[gj]),
          .bin    (brw[gj]),
          .diff   (slice_d[gj]),
          .borrow (brw[gj+1])
        );
      end

      if (gi < STAGES - 1) begin : gen_fwd_upper
        assign a_fwd = a_i[IW-1:SLICE];
        assign b_fwd = b_i[IW-1:SLICE];
      end else begin : gen_fwd_sign
        assign a_fwd = a_i[IW-1];
        assign b_fwd = b_i[IW-1];
      end

      // Next-state: load from upstream when the pipeline advances, else hold.
      always_comb begin
        valid_d  = valid_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        a_d      = a_q;
        b_d      = b_q;
        if (pipe_adv) begin
          valid_d  = v_i;
          borrow_d = brw[SLICE];
          diff_d   = diff_new;
          a_d      = a_fwd;
          b_d      = b_fwd;
        end
      end

      // Stage registers; reset flushes every in-flight operation.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q  <= 1'b0;
          borrow_q <= 1'b0;
          diff_q   <= '0;
          a_q      <= '0;
          b_q      <= '0;
        end else begin
          valid_q  <= valid_d;
          borrow_q <= borrow_d;
          diff_q   <= diff_d;
          a_q      <= a_d;
          b_q      <= b_d;
        end
      end
    end
  endgenerate

  // Output view of the last stage and the shared advance/backpressure logic.
  // Overflow is formed from registered values only, so it stays stable during
  // a stall and reads 0 after reset.
  always_comb begin
    out_valid = gen_stage[STAGES-1].valid_q;
    diff      = gen_stage[STAGES-1].diff_q;
    Bout      = gen_stage[STAGES-1].borrow_q;
    ovf       = sub_overflow(gen_stage[STAGES-1].a_q[0],
                             gen_stage[STAGES-1].b_q[0],
                             gen_stage[STAGES-1].diff_q[WIDTH-1]);
    in_ready  = !out_valid || out_ready;
    pipe_adv  = in_ready;
  end

endmodule

// File: tb/tb_pipelined_ripple_subtractor_32bit.sv
// Scoreboard bench for the pipelined ripple subtractor.
module tb_pipelined_ripple_subtractor_32bit;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B, diff;
  logic         bin, in_valid, in_ready, Bout, ovf, out_valid, out_ready;

  always #5 clk = ~clk;

  pipelined_ripple_subtractor_32bit #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .Bout      (Bout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           acc_cyc;
    bit           chk_lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           lat_mode;
  bit           stalled_prev;
  logic [W-1:0] diff_prev;
  logic         bo_prev, ov_prev;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: 33-bit unsigned difference for borrow, 64-bit signed for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t        e;
    logic [W:0]  r;
    longint      sr;
    r    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    e.d  = r[W-1:0];
    e.bo = r[W];
    sr   = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  // One clock cycle: drive at negedge, observe 1ns later, scoreboard both sides.
  task automatic cycle(input logic r, input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bi, input logic ordy, input exp_t e_in, output bit acc);
    exp_t e, g;
    @(negedge clk);
    cyc++;
    rst = r; in_valid = iv; A = a; B = b; bin = bi; out_ready = ordy;
    #1;
    acc = 1'b0;
    if (stalled_prev) begin
      check_val("stall_out_valid", out_valid, 1);
      check_val("stall_diff", diff, diff_prev);
      check_val("stall_bout", Bout, bo_prev);
      check_val("stall_ovf", ovf, ov_prev);
    end
    if (!rst && out_valid && !out_ready) check_val("stall_in_ready", in_ready, 0);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("spurious_out", out_valid, 0);
      end else begin
        g = sb.pop_front();
        $display("txn cyc=%0d diff=%h Bout=%b ovf=%b", cyc, diff, Bout, ovf);
        check_val("diff", diff, g.d);
        check_val("bout", Bout, g.bo);
        check_val("ovf", ovf, g.ov);
        if (g.chk_lat) check_val("latency", cyc - g.acc_cyc, S);
      end
    end
    if (!rst && iv && in_ready) begin
      e = e_in;
      e.acc_cyc = cyc;
      e.chk_lat = lat_mode;
      sb.push_back(e);
      acc = 1'b1;
    end
    stalled_prev = !rst && out_valid && !out_ready;
    diff_prev = diff; bo_prev = Bout; ov_prev = ovf;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input exp_t e);
    bit acc;
    int tries;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 20) begin
      cycle(1'b0, 1'b1, a, b, bi, 1'b1, e, acc);
      tries++;
    end
    if (!acc) check_val("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit   acc;
    exp_t dummy;
    dummy = model('0, '0, 1'b0);
    for (int k = 0; k < 40 && sb.size() > 0; k++) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, dummy, acc);
    check_val("drain_empty", sb.size(), 0);
  endtask

  function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic ov);
    exp_t e;
    e.d = d; e.bo = bo; e.ov = ov; e.acc_cyc = 0; e.chk_lat = 1'b0;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           acc;
    int           idx;
    logic         ordy;
    logic [W-1:0] av[8];
    logic [W-1:0] bv[8];
    logic         bi_v[8];
    exp_t         dummy;
    logic [W-1:0] ra, rb;
    logic         rbi, riv, rrdy;

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; bin = 1'b0; out_ready = 1'b1;
    stalled_prev = 1'b0; lat_mode = 1'b1;
    dummy = model('0, '0, 1'b0);

    // Reset, then check reset state on the first cycle after release.
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, dummy, acc);
    cycle(1'b1, 1'b1, 32'h1234, 32'h1, 1'b0, 1'b1, dummy, acc);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, dummy, acc);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_diff", diff, 0);
    check_val("rst_bout", Bout, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_in_ready", in_ready, 1);

    // Directed vectors with latency checking.
    send(32'h00000005, 32'h00000003, 1'b0, mk(32'h00000002, 1'b0, 1'b0));
    send(32'h00000000, 32'h00000001, 1'b0, mk(32'hFFFFFFFF, 1'b1, 1'b0));
    send(32'h80000000, 32'h00000001, 1'b0, mk(32'h7FFFFFFF, 1'b0, 1'b1));
    send(32'h00000010, 32'h0000000F, 1'b1, mk(32'h00000000, 1'b0, 1'b0));
    drain();

    // Eight back-to-back operations with a three-cycle output stall.
    lat_mode = 1'b0;
    av[0] = 32'h7FFFFFFF; bv[0] = 32'hFFFFFFFF; bi_v[0] = 1'b0;
    av[1] = 32'h00000000; bv[1] = 32'h00000000; bi_v[1] = 1'b1;
    for (int i = 2; i < 8; i++) begin
      av[i] = $urandom; bv[i] = $urandom; bi_v[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    for (int k = 0; k < 40 && idx < 8; k++) begin
      ordy = !(k >= 5 && k <= 7);
      cycle(1'b0, 1'b1, av[idx], bv[idx], bi_v[idx], ordy, model(av[idx], bv[idx], bi_v[idx]), acc);
      if (acc) idx++;
    end
    check_val("stream_all_sent", idx, 8);
    drain();

    // Random traffic with random backpressure and bubbles.
    for (int k = 0; k < 60; k++) begin
      ra = $urandom; rb = $urandom; rbi = 1'($urandom_range(0, 1));
      riv = 1'($urandom_range(0, 3) != 0); rrdy = 1'($urandom_range(0, 2) != 0);
      cycle(1'b0, riv, ra, rb, rbi, rrdy, model(ra, rb, rbi), acc);
    end
    drain();

    // Reset with three operations in flight: none may ever emerge.
    lat_mode = 1'b1;
    send(32'h00000009, 32'h00000001, 1'b0, model(32'h9, 32'h1, 1'b0));
    send(32'h00000100, 32'h00000200, 1'b0, model(32'h100, 32'h200, 1'b0));
    send(32'hDEADBEEF, 32'h12345678, 1'b1, model(32'hDEADBEEF, 32'h12345678, 1'b1));
    cycle(1'b1, 1'b1, 32'h55, 32'h11, 1'b0, 1'b1, dummy, acc);
    sb.delete();
    stalled_prev = 1'b0;
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, dummy, acc);
    check_val("post_rst_out_valid", out_valid, 0);
    check_val("post_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, dummy, acc);
      check_val("post_rst_quiet", out_valid, 0);
    end
    send(32'h00000064, 32'h00000032, 1'b0, mk(32'h00000032, 1'b0, 1'b0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
